// File: rtl/oflow_dma_set_feeder.sv
// Reads one frame's bboxes from a sync-read memory, packs them into PE_NUM-wide sets and hands
// them to oflow_core, prefetching the next set into a staging buffer while the core works.
module oflow_dma_set_feeder #(
  parameter int PE_NUM   = 24,
  parameter int BBOX_W   = 86,
  parameter int MAX_BBOX = 72,
  parameter int CNT_W    = 7,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start,
  input  logic              frame_req,
  input  logic [CNT_W-1:0]  frame_bbox_count,
  input  logic [ADDR_W-1:0] frame_base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BBOX_W-1:0] mem_rd_data,
  output logic [BBOX_W-1:0] set_of_bboxes_from_dma [PE_NUM],
  output logic              new_frame,
  output logic              new_set_from_dma,
  input  logic              ready_new_set,
  input  logic              ready_new_frame,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ISSUE, S_WAIT_END} state_t;

  localparam int SLOT_W = $clog2(PE_NUM + 1);
  localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(PE_NUM);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BBOX);

  state_t state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W:0]    glob;
  logic [SLOT_W-1:0] slot, cap_slot;
  logic cap_q, rd_q;
  logic first_frame, first_set, pend_set, pend_frame, prev_set, prev_frame;
  logic set_rise, frame_rise, set_ok, frame_ok, reading, more_sets;
  logic [BBOX_W-1:0] staging [PE_NUM];

  assign set_rise   = ready_new_set & ~prev_set;
  assign frame_rise = ready_new_frame & ~prev_frame;
  assign set_ok     = pend_set | set_rise;
  assign frame_ok   = pend_frame | frame_rise;
  assign reading    = (state == S_LOAD) && (slot < SLOT_END);
  // glob keeps counting through zero-filled slots, so after a set it equals (sets done)*PE_NUM
  assign more_sets  = glob < {1'b0, cnt};

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (frame_req && frame_bbox_count != '0) next_state = S_LOAD;
      S_LOAD:     if (slot == SLOT_END) next_state = S_WAIT;
      S_WAIT:     if (first_set ? (first_frame | frame_ok) : set_ok) next_state = S_ISSUE;
      S_ISSUE:    next_state = more_sets ? S_LOAD : S_WAIT_END;
      S_WAIT_END: if (frame_ok) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en        = 1'b0;
    mem_addr         = '0;
    new_frame        = 1'b0;
    new_set_from_dma = 1'b0;
    busy             = (state != S_IDLE);
    if (reading && more_sets) begin
      mem_rd_en = 1'b1;
      mem_addr  = base + ADDR_W'(glob);
    end
    if (state == S_ISSUE) begin
      new_frame        = first_set;
      new_set_from_dma = ~first_set;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt         <= '0;
      base        <= '0;
      glob        <= '0;
      slot        <= '0;
      first_set   <= 1'b0;
      first_frame <= 1'b1;
      pend_set    <= 1'b0;
      pend_frame  <= 1'b0;
      prev_set    <= 1'b0;
      prev_frame  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      prev_set   <= ready_new_set;
      prev_frame <= ready_new_frame;
      pend_set   <= pend_set | set_rise;
      pend_frame <= pend_frame | frame_rise;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (frame_req) begin
          if (frame_bbox_count == '0) frame_done <= 1'b1;
          cnt       <= (frame_bbox_count > CNT_MAX) ? CNT_MAX : frame_bbox_count;
          base      <= frame_base_addr;
          glob      <= '0;
          slot      <= '0;
          first_set <= 1'b1;
        end
        S_LOAD: if (reading) begin
          slot <= slot + 1'b1;
          glob <= glob + 1'b1;
        end else begin
          slot <= '0;
        end
        S_WAIT: if (next_state == S_ISSUE) begin
          pend_set   <= 1'b0;
          pend_frame <= 1'b0;
        end
        S_ISSUE: first_set <= 1'b0;
        S_WAIT_END: if (frame_ok) begin
          frame_done  <= 1'b1;
          first_frame <= 1'b0;
          pend_frame  <= 1'b0;
        end
        default: ;
      endcase
      if (start) first_frame <= 1'b1;
    end
  end

  // read data lands one cycle after the strobe; slots past the frame end are written as zero
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cap_q    <= 1'b0;
      rd_q     <= 1'b0;
      cap_slot <= '0;
    end else begin
      cap_q    <= reading;
      rd_q     <= mem_rd_en;
      cap_slot <= slot;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < PE_NUM; i++) staging[i] <= '0;
    end else if (cap_q) begin
      staging[cap_slot] <= rd_q ? mem_rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < PE_NUM; i++) set_of_bboxes_from_dma[i] <= '0;
    end else if (state == S_WAIT && next_state == S_ISSUE) begin
      set_of_bboxes_from_dma <= staging;
    end
  end

endmodule

// File: tb/tb_oflow_dma_set_feeder.sv
// Scoreboard bench for oflow_dma_set_feeder: directed frames, expected sets/pulses queued with
// the cycle they must appear in, and a monitor that checks every pulse the DUT produces.
module tb_oflow_dma_set_feeder;
  localparam int PE_NUM = 24, BBOX_W = 86, MAX_BBOX = 72, CNT_W = 7, ADDR_W = 10;
  localparam int FLAT_W = PE_NUM * BBOX_W;
  localparam int LAT    = PE_NUM + 3;

  typedef struct packed {
    logic [1:0]        kind;
    int                due;
    logic [FLAT_W-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_N, start, frame_req, mem_rd_en, new_frame, new_set_from_dma;
  logic ready_new_set, ready_new_frame, busy, frame_done;
  logic [CNT_W-1:0]  frame_bbox_count;
  logic [ADDR_W-1:0] frame_base_addr, mem_addr;
  logic [BBOX_W-1:0] mem_rd_data;
  logic [BBOX_W-1:0] set_of_bboxes_from_dma [PE_NUM];

  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, k, i;

  oflow_dma_set_feeder #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .MAX_BBOX(MAX_BBOX),
                         .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .frame_req(frame_req),
    .frame_bbox_count(frame_bbox_count), .frame_base_addr(frame_base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .set_of_bboxes_from_dma(set_of_bboxes_from_dma), .new_frame(new_frame),
    .new_set_from_dma(new_set_from_dma), .ready_new_set(ready_new_set),
    .ready_new_frame(ready_new_frame), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BBOX_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return {6'h2A, 60'h0, a, a};
  endfunction

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_val(mem_addr) : '0;

  function automatic logic [FLAT_W-1:0] build_set(input int base, input int first, input int count);
    logic [FLAT_W-1:0] f = '0;
    for (int s = 0; s < PE_NUM; s++)
      if (first + s < count) f[s*BBOX_W +: BBOX_W] = mem_val(ADDR_W'(base + first + s));
    return f;
  endfunction

  function automatic logic [FLAT_W-1:0] dut_flat();
    logic [FLAT_W-1:0] f;
    for (int s = 0; s < PE_NUM; s++) f[s*BBOX_W +: BBOX_W] = set_of_bboxes_from_dma[s];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_set(input string name, input logic [FLAT_W-1:0] got, input logic [FLAT_W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      for (int s = 0; s < PE_NUM; s++)
        if (got[s*BBOX_W +: BBOX_W] !== want[s*BBOX_W +: BBOX_W]) begin
          $display("FAIL %s slot %0d: got 0x%0h expected 0x%0h (cyc %0d)", name, s,
                   got[s*BBOX_W +: BBOX_W], want[s*BBOX_W +: BBOX_W], cyc);
          break;
        end
    end
  endtask

  task automatic expect_evt(input int kind, input int due, input logic [FLAT_W-1:0] dat);
    exp_t e;
    e.kind = 2'(kind);
    e.due  = due;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0 (cyc %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input int count, input int base);
    frame_req = 1'b1;
    frame_bbox_count = CNT_W'(count);
    frame_base_addr = ADDR_W'(base);
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_set();
    ready_new_set = 1'b1;
    @(negedge clk);
    ready_new_set = 1'b0;
  endtask

  task automatic pulse_frame();
    ready_new_frame = 1'b1;
    @(negedge clk);
    ready_new_frame = 1'b0;
  endtask

  initial begin
    reset_N = 1'b0; start = 1'b0; frame_req = 1'b0; frame_bbox_count = '0;
    frame_base_addr = '0; ready_new_set = 1'b0; ready_new_frame = 1'b0;

    fork
      forever begin
        int kind;
        exp_t e;
        @(negedge clk);
        if (reset_N) begin
          if (new_frame && new_set_from_dma) check("pulse_overlap", 32'd1, 32'd0);
          if (new_frame || new_set_from_dma || frame_done) begin
            kind = new_frame ? 0 : (new_set_from_dma ? 1 : 2);
            if (exp_q.size() == 0) begin
              check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("event_kind", 32'(kind), 32'(e.kind));
              check("event_cycle", 32'(cyc), 32'(e.due));
              if (kind < 2) check_set("set_data", dut_flat(), e.dat);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_ctrl", {26'd0, busy, mem_rd_en, new_frame, new_set_from_dma, frame_done,
                         1'b0} | 32'(mem_addr), 32'd0);
    check_set("reset_set", dut_flat(), '0);
    reset_N = 1'b1;
    repeat (2) @(negedge clk);

    // first frame of 72: three full sets
    pulse_start();
    k = cyc;
    expect_evt(0, k + LAT, build_set(0, 0, 72));
    send_frame(72, 0);
    check("busy_after_req", 32'(busy), 32'd1);
    drain(40);
    wait_cyc(cyc + 30);
    expect_evt(1, cyc + 1, build_set(0, 24, 72));
    pulse_set();
    drain(10);
    wait_cyc(cyc + 30);
    expect_evt(1, cyc + 1, build_set(0, 48, 72));
    pulse_set();
    drain(10);
    wait_cyc(cyc + 5);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);
    check("busy_after_done", 32'(busy), 32'd0);

    // partial frame of 30: second set zero-filled from slot 6
    pulse_start();
    k = cyc;
    expect_evt(0, k + LAT, build_set(100, 0, 30));
    send_frame(30, 100);
    drain(40);
    wait_cyc(cyc + 30);
    expect_evt(1, cyc + 1, build_set(100, 24, 30));
    pulse_set();
    drain(10);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);

    // non-first frame: waits for ready_new_frame; addresses wrap past 1023
    k = cyc;
    send_frame(24, 1020);
    wait_cyc(k + 40);
    expect_evt(0, cyc + 1, build_set(1020, 0, 24));
    pulse_frame();
    drain(10);
    wait_cyc(cyc + 5);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);

    // ready_new_set rises during the prefetch load
    pulse_start();
    k = cyc;
    i = k + LAT;
    expect_evt(0, i, build_set(200, 0, 72));
    send_frame(72, 200);
    expect_evt(1, i + LAT, build_set(200, 24, 72));
    wait_cyc(i + 3);
    pulse_set();
    drain(60);
    wait_cyc(cyc + 40);
    expect_evt(1, cyc + 1, build_set(200, 48, 72));
    pulse_set();
    drain(10);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);

    // empty frame, then a frame_req while busy
    k = cyc;
    expect_evt(2, k + 1, '0);
    send_frame(0, 0);
    drain(5);
    check("busy_empty_frame", 32'(busy), 32'd0);
    pulse_start();
    k = cyc;
    expect_evt(0, k + LAT, build_set(300, 0, 24));
    send_frame(24, 300);
    wait_cyc(k + 5);
    send_frame(48, 500);
    drain(40);
    wait_cyc(cyc + 5);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);
    wait_cyc(cyc + 60);
    check("busy_idle_after_ignored", 32'(busy), 32'd0);

    // reset in the middle of a load
    k = cyc;
    send_frame(72, 0);
    wait_cyc(k + 10);
    check("rd_en_mid_load", 32'(mem_rd_en), 32'd1);
    reset_N = 1'b0;
    #1;
    check("async_reset_ctrl", {27'd0, busy, mem_rd_en, new_frame, new_set_from_dma, frame_done},
          32'd0);
    check_set("async_reset_set", dut_flat(), '0);
    repeat (2) @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    k = cyc;
    expect_evt(0, k + LAT, build_set(40, 0, 24));
    send_frame(24, 40);
    drain(40);
    wait_cyc(cyc + 5);
    expect_evt(2, cyc + 1, '0);
    pulse_frame();
    drain(10);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
